// File: rtl/uart_pkg.sv
// Shared types and legal parameter ranges for the FIFO-fed UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int DSIZE_MIN     = 5;
  localparam int DSIZE_MAX     = 9;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-time divider: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_reg;

  assign tick = (cnt_reg == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clear || tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains the FIFO read port and serialises each word as a UART frame:
// start, data LSB first, optional even parity, then one or two stop bits.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int DSIZE        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             tx_en,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic             txd,
  output logic             busy,
  output logic             frame_done
);

  localparam int BW = $clog2(DSIZE + 1);

  if (DSIZE < DSIZE_MIN || DSIZE > DSIZE_MAX) begin : g_bad_dsize
    $error("fifo_uart_tx: DSIZE out of range");
  end
  if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop
    $error("fifo_uart_tx: STOP_BITS out of range");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("fifo_uart_tx: CLKS_PER_BIT must be at least 2");
  end

  uart_state_e      state_reg, state_next;
  logic [DSIZE-1:0] shreg_reg, shreg_next;
  logic             parity_reg, parity_next;
  logic [BW-1:0]    bit_cnt_reg, bit_cnt_next;
  logic             stop_cnt_reg, stop_cnt_next;
  logic             frame_done_reg, frame_done_next;
  logic             tick;
  logic             last_stop;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (rclk),
    .rst_n(rrst_n),
    .clear((state_reg == IDLE) || rinc),
    .tick (tick)
  );

  assign last_stop = (state_reg == STOP) && tick && (stop_cnt_reg == 1'(STOP_BITS - 1));

  // Combinational pop so the FIFO sees rinc on the same edge it presents rempty;
  // gated by reset because the state sits in IDLE while reset is held.
  assign rinc = rrst_n && tx_en && !rempty && ((state_reg == IDLE) || last_stop);

  always_comb begin
    state_next      = state_reg;
    shreg_next      = shreg_reg;
    parity_next     = parity_reg;
    bit_cnt_next    = bit_cnt_reg;
    stop_cnt_next   = stop_cnt_reg;
    frame_done_next = last_stop;

    case (state_reg)
      IDLE: ;
      START: begin
        if (tick) begin
          state_next   = DATA;
          bit_cnt_next = '0;
        end
      end
      DATA: begin
        if (tick) begin
          shreg_next = shreg_reg >> 1;
          if (bit_cnt_reg == BW'(DSIZE - 1)) begin
            state_next    = (PARITY_EN != 0) ? PARITY : STOP;
            stop_cnt_next = 1'b0;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_next    = STOP;
          stop_cnt_next = 1'b0;
        end
      end
      STOP: begin
        if (last_stop) begin
          state_next = IDLE;
        end else if (tick) begin
          stop_cnt_next = stop_cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // A pop overrides the end-of-frame return to IDLE, chaining frames with no gap.
    if (rinc) begin
      state_next    = START;
      shreg_next    = rdata;
      parity_next   = ^rdata;
      bit_cnt_next  = '0;
      stop_cnt_next = 1'b0;
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_reg      <= IDLE;
      shreg_reg      <= '0;
      parity_reg     <= 1'b0;
      bit_cnt_reg    <= '0;
      stop_cnt_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      shreg_reg      <= shreg_next;
      parity_reg     <= parity_next;
      bit_cnt_reg    <= bit_cnt_next;
      stop_cnt_reg   <= stop_cnt_next;
      frame_done_reg <= frame_done_next;
    end
  end

  always_comb begin
    txd = 1'b1;
    case (state_reg)
      START:   txd = 1'b0;
      DATA:    txd = shreg_reg[0];
      PARITY:  txd = parity_reg;
      default: txd = 1'b1;
    endcase
  end

  assign busy       = (state_reg != IDLE);
  assign frame_done = frame_done_reg;

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Read-side drain stage for the asynchronous FIFO. It pops words from the FIFO read port (`rdata`/`rempty`/`rinc`) in the `rclk` domain and serialises each one onto a UART line: start bit, data LSB first, optional even parity, then stop bit(s). It is the consumer that turns the FIFO into a clock-crossing UART transmit path.

## Interface
Parameters:
- `DSIZE`, 8: data bits per frame; must match the FIFO `DSIZE`; legal range 5–9.
- `CLKS_PER_BIT`, 16: `rclk` cycles per UART bit; must be ≥ 2.
- `PARITY_EN`, 0: 1 appends an even-parity bit after the data bits.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.

Ports:
- `rclk` input 1: the block's only clock, the FIFO read clock.
- `rrst_n` input 1: asynchronous, active-low reset.
- `tx_en` input 1: permits new frames to start.
- `rempty` input 1: FIFO empty flag.
- `rdata` input DSIZE: FIFO head word. Valid whenever `rempty`=0; not registered by the FIFO.
- `rinc` output 1: FIFO pop strobe; asserted for exactly one cycle per word.
- `txd` output 1: serial line; idles high.
- `busy` output 1: high from the cycle after a pop until the end of the last stop bit.
- `frame_done` output 1: one-cycle pulse after the last stop bit completes.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Pop condition: `rinc` = `tx_en` & !`rempty` & (state==IDLE | (state==STOP & last tick of last stop bit)). It is combinational so that `rinc` and `rempty` are sampled on the same edge.
- On each `rclk` edge with `rinc`=1:
  - `rdata` is captured into the shift register.
  - Parity is computed as XOR of `rdata`.
  - The baud counter clears and the state goes to START.
- START: `txd`=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: `txd`=shreg[0], held CLKS_PER_BIT cycles per bit. The register shifts right at each bit end. After DSIZE bits, go to PARITY if PARITY_EN, else STOP.
- PARITY: `txd`=parity bit (even, i.e. the XOR of the data) for one bit time, then STOP.
- STOP: `txd`=1 for STOP_BITS×CLKS_PER_BIT cycles. At the end:
  - If the pop condition is true, go to START (back-to-back, no idle gap).
  - Otherwise go to IDLE.
- `tx_en` deasserted mid-frame: the current frame completes normally and no further pop occurs.
- `rempty` rising mid-frame has no effect on the current frame.
- Counter widths:
  - Baud counter: $clog2(CLKS_PER_BIT) bits, counts 0..CLKS_PER_BIT-1 and wraps.
  - Bit counter: $clog2(DSIZE+1) bits.
  - Stop counter: 1 bit.
- Reset (asynchronous, any state): state IDLE, `txd`=1, `busy`=0, `frame_done`=0, `rinc`=0, counters and shift register 0. A frame in flight is aborted and its word is lost. The line returns high in the reset cycle.

## Timing
- Pop at edge T0 gives `txd`=0 starting the cycle after T0, i.e. one cycle of latency.
- Frame length: CLKS_PER_BIT×(1+DSIZE+PARITY_EN+STOP_BITS) cycles.
- Back-to-back frames follow with zero idle cycles.
- `frame_done` is asserted in the first cycle after the final stop bit, and also in the cycle a chained START begins.
- `busy` is high from T0+1 through the last stop-bit cycle. It stays high across chained frames.
- `rinc` is never asserted while `rempty`=1, and never asserted during reset.

## Structure
- Shared package `uart_pkg`: the FSM state enum (IDLE, START, DATA, PARITY, STOP) and the legal-range constants for DSIZE and STOP_BITS.
- One natural sub-module, `uart_baud_tick`: the CLKS_PER_BIT counter. It has a clear input and a one-cycle `tick` output on the last cycle of each bit.
- The top level instantiates it beside `fifo1`, with `rinc`/`rdata`/`rempty` wired directly.

## Test plan
All scenarios use CLKS_PER_BIT=4, DSIZE=8, STOP_BITS=1 unless stated.
- Reset, `rempty`=1 for 100 cycles -> `txd`=1, `rinc`=0, `busy`=0 throughout.
- One word 0xA5, PARITY_EN=0 -> one `rinc` pulse; `txd` sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; 40-cycle frame; `frame_done` pulses once.
- Three words 0x00, 0xFF, 0x3C queued -> three `rinc` pulses 40 cycles apart; no idle high gap between frames; `busy` continuously high for 120 cycles.
- PARITY_EN=1, STOP_BITS=2, word 0x07 -> parity bit 1; 48-cycle frame; stop high for 8 cycles.
- `tx_en` dropped during DATA with two words queued -> the current frame completes, the second word is not popped, `rempty` stays 0.
- `rrst_n` asserted mid-DATA -> `txd`=1 and `busy`=0 immediately. After release with the FIFO non-empty, the next word starts cleanly with a full START bit.
